led_rate_divider: RTL and testbench

Programmable rate generator that sits directly upstream of the side-to-side LED bouncer: it divides the 50 MHz board clock down to the slow step clock that advances the LED pattern. It produces a square-wave `slow_clk` (driven into the bouncer's clock input) and a one-cycle `tick_out` pulse per step. It also provides run-time speed changes, a pause, and single-step control.

---
 rtl/led_rate_divider.sv | 52 +++++
 tb/tb_led_rate_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_rate_divider.sv
// led_rate_divider: programmable step-clock generator with pause, single-step and glitch-free divisor reload
module led_rate_divider #(
  parameter int CNT_WIDTH   = 32,
  parameter int DEFAULT_DIV = 25_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] div_value,
  input  logic                 div_load,
  input  logic                 pause,
  input  logic                 step,
  output logic                 tick_out,
  output logic                 slow_clk,
  output logic [CNT_WIDTH-1:0] div_active,
  output logic                 paused
);
  typedef enum logic {RUN, PAUSED} state_t;
  state_t state;
  logic [CNT_WIDTH-1:0] cnt, pend_div, san;
  logic pend_valid, do_count, fire;
  // the edge that releases pause already counts, so counting depends only on the pause level
  always_comb begin
    san = div_value == '0 ? CNT_WIDTH'(1) : div_value;
    do_count = !pause;
    fire = (do_count && cnt == div_active - CNT_WIDTH'(1)) || (state == PAUSED && pause && step);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      div_active <= CNT_WIDTH'(DEFAULT_DIV);
      pend_div <= '0;
      pend_valid <= 1'b0;
      state <= RUN;
      tick_out <= 1'b0;
      slow_clk <= 1'b0;
      paused <= 1'b0;
    end else begin
      state <= pause ? PAUSED : RUN;
      paused <= pause;
      tick_out <= fire;
      slow_clk <= slow_clk ^ fire;
      cnt <= fire ? '0 : do_count ? cnt + CNT_WIDTH'(1) : cnt;
      if (fire) begin
        div_active <= div_load ? san : pend_valid ? pend_div : div_active;
        pend_valid <= 1'b0;
      end else if (div_load) begin
        pend_div <= san;
        pend_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_rate_divider.sv
// tb_led_rate_divider: scenario tasks push expected outputs per edge and compare them after the edge
module tb_led_rate_divider;
  localparam int W = 32;
  typedef logic [W+2:0] obs_t;
  logic clk = 1'b0;
  logic reset, div_load, pause, step;
  logic [W-1:0] div_value;
  logic tick_out, slow_clk, paused;
  logic [W-1:0] div_active;
  obs_t sb[$];
  obs_t e, got;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_rate_divider #(.CNT_WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .div_value(div_value), .div_load(div_load),
    .pause(pause), .step(step), .tick_out(tick_out), .slow_clk(slow_clk),
    .div_active(div_active), .paused(paused)
  );

  task automatic idle();
    reset = 1'b0;
    div_load = 1'b0;
    div_value = '0;
    pause = 1'b0;
    step = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    advance();
    reset = 1'b0;
  endtask

  task automatic push(input logic t, input logic s, input logic [W-1:0] d, input logic p);
    sb.push_back({t, s, d, p});
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      idle();
      reset = 1'b1;
      pause = 1'b1;
      step = 1'b1;
      div_load = 1'b1;
      div_value = 9;
      push(0, 0, 4, 0);
      advance();
      e = sb.pop_front();
      got = {tick_out, slow_clk, div_active, paused};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset k=%0d got %h exp %h", k, got, e);
      end
    end
    idle();
  endtask

  task automatic test_default();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      push(k % 4 == 0, (k / 4) % 2, 4, 0);
      advance();
      e = sb.pop_front();
      got = {tick_out, slow_clk, div_active, paused};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL default k=%0d got %h exp %h", k, got, e);
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      div_load = (k == 2);
      div_value = 2;
      if (k < 4) push(0, 0, 4, 0);
      else push((k - 4) % 2 == 0, (1 + (k - 4) / 2) % 2, 2, 0);
      advance();
      e = sb.pop_front();
      got = {tick_out, slow_clk, div_active, paused};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL load k=%0d got %h exp %h", k, got, e);
      end
    end
    idle();
  endtask

  task automatic test_last_wins_and_zero();
    do_reset();
    for (int k = 1; k <= 28; k++) begin
      div_load = (k == 1) || (k == 2) || (k == 18);
      div_value = (k == 1) ? 3 : (k == 2) ? 6 : 0;
      if (k < 4) push(0, 0, 4, 0);
      else if (k < 22) push((k - 4) % 6 == 0, (1 + (k - 4) / 6) % 2, 6, 0);
      else push(1, (k - 22) % 2, 1, 0);
      advance();
      e = sb.pop_front();
      got = {tick_out, slow_clk, div_active, paused};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL last_wins_zero k=%0d got %h exp %h", k, got, e);
      end
    end
    idle();
  endtask

  task automatic test_pause();
    int x;
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      pause = (k >= 3 && k <= 12);
      x = (k < 3) ? k : (k <= 12) ? 2 : k - 10;
      push(x >= 4 && x % 4 == 0, (x / 4) % 2, 4, k >= 3 && k <= 12);
      advance();
      e = sb.pop_front();
      got = {tick_out, slow_clk, div_active, paused};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pause k=%0d got %h exp %h", k, got, e);
      end
    end
    idle();
  endtask

  task automatic test_step();
    logic t, s;
    s = 1'b0;
    do_reset();
    for (int k = 1; k <= 26; k++) begin
      pause = (k >= 2 && k <= 17);
      step = (k == 5) || (k == 10) || (k == 15) || (k == 23);
      t = (k == 5) || (k == 10) || (k == 15) || (k == 21) || (k == 25);
      s = s ^ t;
      push(t, s, 4, k >= 2 && k <= 17);
      advance();
      e = sb.pop_front();
      got = {tick_out, slow_clk, div_active, paused};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL step k=%0d got %h exp %h", k, got, e);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      idle();
      div_value = 2;
      div_load = (k == 5) || (k == 6);
      reset = (k == 6);
      pause = (k == 6);
      step = (k == 6);
      if (k < 6) push(k == 4, k >= 4, 4, 0);
      else if (k == 6) push(0, 0, 4, 0);
      else push((k - 6) % 4 == 0, ((k - 6) / 4) % 2, 4, 0);
      advance();
      e = sb.pop_front();
      got = {tick_out, slow_clk, div_active, paused};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid k=%0d got %h exp %h", k, got, e);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_default();
    test_load();
    test_last_wins_and_zero();
    test_pause();
    test_step();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
